// File: rtl/nibble_serial_add32.sv
// nibble_serial_add32: 32-bit add/subtract computed one nibble per clock on a single shared 4-bit ripple slice.
module adder1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        adder1 u_bit (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
    assign co = c[4];
endmodule

module nibble_serial_add32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, acc_q, acc_d, sum_q, sum_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d, cout_q, cout_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [3:0]  slice_s;
    logic        slice_co;

    adder4 u_slice (.a(a_sh_q[3:0]), .b(b_sh_q[3:0]), .ci(carry_q), .s(slice_s), .co(slice_co));

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_sh_d  = a;
                b_sh_d  = sub ? ~b : b;
                carry_d = sub ? 1'b1 : cin;
                cnt_d   = 3'd0;
                state_d = RUN;
            end
            RUN: begin
                acc_d   = {slice_s, acc_q[31:4]};
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                carry_d = slice_co;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    sum_d       = acc_d;
                    cout_d      = slice_co;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_nibble_serial_add32.sv
// tb_nibble_serial_add32: randomized scoreboard bench for the nibble-serial 32-bit adder/subtractor.
module tb_nibble_serial_add32;
    logic        clk = 0, rst = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic        in_ready, out_valid, cout, busy;
    logic [31:0] sum;

    nibble_serial_add32 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, n_acc = 0, acc_cyc = 0, hs_cyc = 0;
    logic [32:0] exp_q[$];
    int          tim_q[$];
    logic rnd_en = 0, ready_val = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
        logic [31:0] eb;
        eb = s ? ~y : y;
        return {1'b0, x} + {1'b0, eb} + 33'(s ? 1'b1 : c);
    endfunction

    // Accept/handshake observer: expectations are queued at the accept edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            tim_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                tim_q.push_back(cyc);
                acc_cyc = cyc;
                n_acc++;
            end
            if (out_valid && out_ready) hs_cyc = cyc;
        end
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        out_ready = rnd_en ? ($urandom_range(0, 3) != 0) : ready_val;
    end

    // Monitor: compares each new result and its latency, and checks hold/flag invariants.
    logic        prev_ov = 0;
    logic [32:0] prev_res;
    always @(negedge clk) begin
        if (rst) prev_ov = 0;
        else begin
            if (in_ready !== !busy) chk("ready_vs_busy", {63'd0, in_ready}, {63'd0, !busy});
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
                else begin
                    logic [32:0] e;
                    int t;
                    e = exp_q.pop_front();
                    t = tim_q.pop_front();
                    chk("result", {31'd0, cout, sum}, {31'd0, e});
                    chk("latency", 64'(cyc - t - 1), 64'd8);
                    chk("ready_in_done", {63'd0, in_ready}, 64'd0);
                end
            end else if (out_valid && prev_ov)
                chk("hold_result", {31'd0, cout, sum}, {31'd0, prev_res});
            prev_ov  = out_valid;
            prev_res = {cout, sum};
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
        int na;
        na = n_acc;
        a = x; b = y; cin = c; sub = s; in_valid = 1;
        for (int i = 0; i < 300 && n_acc == na; i++) begin
            @(posedge clk); #1;
        end
        if (n_acc == na) chk("accept_timeout", 64'd1, 64'd0);
        in_valid = 0;
    endtask

    task automatic wait_ov(output logic ok);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (out_valid) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) chk("out_valid_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_dir(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic c, input logic s, input logic [32:0] e);
        logic ok;
        send(x, y, c, s);
        wait_ov(ok);
        if (ok) chk(name, {31'd0, cout, sum}, {31'd0, e});
        for (int i = 0; i < 30 && !in_ready; i++) begin @(posedge clk); #1; end
        chk({name, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic ok;
        logic [31:0] held_s;
        logic        held_c;
        int          na;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_sum_cout", {31'd0, cout, sum}, 64'd0);
        rst = 0;
        @(posedge clk); #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        run_dir("basic_add", 32'h0000_000F, 32'h1, 0, 0, {1'b0, 32'h0000_0010});
        run_dir("ripple_ff", 32'hFFFF_FFFF, 32'h0, 1, 0, {1'b1, 32'h0});
        run_dir("ripple_msb", 32'h8000_0000, 32'h8000_0000, 0, 0, {1'b1, 32'h0});
        run_dir("sub_neg", 32'd5, 32'd7, 1, 1, {1'b0, 32'hFFFF_FFFE});
        run_dir("sub_pos", 32'd7, 32'd5, 0, 1, {1'b1, 32'd2});

        ready_val = 0;
        send(32'h1234_5678, 32'h1111_1111, 0, 0);
        wait_ov(ok);
        held_s = sum; held_c = cout;
        chk("bp_result", {31'd0, held_c, held_s}, {31'd0, 1'b0, 32'h2345_6789});
        na = n_acc;
        a = 32'hDEAD_BEEF; b = 32'h1; cin = 0; sub = 0; in_valid = 1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", {31'd0, cout, sum}, {31'd0, held_c, held_s});
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_no_accept", 64'(n_acc), 64'(na));
        end
        ready_val = 1;
        for (int i = 0; i < 20 && n_acc == na; i++) begin @(posedge clk); #1; end
        in_valid = 0;
        chk("bp_accept_gap", 64'(acc_cyc - hs_cyc), 64'd1);
        wait_ov(ok);
        if (ok) chk("bp_second", {31'd0, cout, sum}, {31'd0, 1'b0, 32'hDEAD_BEF0});
        for (int i = 0; i < 30 && !in_ready; i++) begin @(posedge clk); #1; end

        send(32'h1, 32'h1, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_sum_cout", {31'd0, cout, sum}, 64'd0);
        ok = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1;
        end
        chk("midrst_no_result", {63'd0, ok}, 64'd0);
        run_dir("after_rst", 32'd3, 32'd4, 0, 0, {1'b0, 32'd7});

        rnd_en = 1;
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = ~x;
            if ($urandom_range(0, 7) == 0) y = x;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(x, y, 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add32.md
# nibble_serial_add32

Multi-cycle sequencer that computes a 32-bit add or subtract on one shared `adder4` slice, processing one nibble per clock. It serves area-constrained paths where a full `adder32` ripple chain is too large. A valid/ready handshake sits on the operand side and another on the result side. It instantiates exactly one `adder4` (4-bit ripple of `adder1` cells) and owns all operand shifting, carry sequencing and result capture around it.

## Interface
- No parameters. Width is fixed at 32 bits and the slice width at 4 bits.
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand request
- `in_ready`  out  1  block can accept an operand; combinational, equals (state == IDLE)
- `a`  in  32  operand A, sampled only on the accept edge
- `b`  in  32  operand B, sampled only on the accept edge
- `cin`  in  1  carry-in for add; ignored when `sub` = 1
- `sub`  in  1  0: a + b + cin; 1: a - b, computed as a + ~b + 1
- `out_valid`  out  1  result available; registered
- `out_ready`  in  1  consumer accepts the result
- `sum`  out  32  registered result
- `cout`  out  1  registered carry-out; on subtract it means no-borrow (1 when a >= b unsigned)
- `busy`  out  1  registered; 1 in RUN or DONE

## Operation
- **States:** IDLE, RUN, DONE. Encoding is free.
- **IDLE:**
  - On `in_valid & in_ready`, latch `a` into `a_sh` and the effective B (`sub ? ~b : b`) into `b_sh`.
  - Set `carry` to `sub ? 1 : cin` and `cnt` to 0, then go to RUN.
- **RUN, every cycle:**
  - The `adder4` slice receives `a_sh[3:0]`, `b_sh[3:0]` and `carry`.
  - Its nibble sum shifts into `acc[31:28]` while `acc` shifts right by 4.
  - `a_sh` and `b_sh` shift right by 4; `carry` takes the slice `cout`; `cnt` increments.
- **RUN exit:** on the cycle with `cnt` == 7, the next edge loads `sum` with the final `acc` value (including that nibble) and `cout` with the slice `cout`. The same edge sets `out_valid` = 1 and moves to DONE.
- **DONE:**
  - Hold `sum`, `cout` and `out_valid` stable.
  - On `out_valid & out_ready`, clear `out_valid` and go to IDLE.
  - `in_valid` is ignored; no operand is accepted in DONE.
- `sum` and `cout` change only on the RUN→DONE edge and on reset. Outside DONE they hold the last completed result.
- **Width rule:** 32-bit result is modulo 2^32. `cout` is bit 32 of a + b' + c', where b' is the effective B and c' is the effective carry-in.
- **Reset:** `rst` = 1 at an edge forces IDLE, `out_valid` = 0, `busy` = 0, `sum` = 0, `cout` = 0, `cnt` = 0 and `carry` = 0. `in_ready` reads 1 from the first cycle after reset deasserts.
- **Reset mid-operation (RUN or DONE):** the operation is aborted and no result is produced. A `rst` edge coincident with the RUN→DONE or DONE→IDLE edge wins.

## Timing
- Accept edge E0, where `in_valid & in_ready` is sampled high. Nibble k is computed in the cycle after E(k) and registered at E(k+1), for k = 0..7.
- `out_valid` rises at E8: latency is 8 cycles from accept to result.
- With `out_ready` held high, the handshake completes at E9 and `in_ready` is 1 in the cycle after E9. The next accept is at E10 at the earliest.
- Minimum issue interval is 10 cycles, and there is no bypass from DONE to RUN.
- Back-pressure: DONE is held indefinitely while `out_ready` = 0.
- `in_ready` is 0 from the cycle after E0 until the cycle after the result handshake.
- `busy` is 1 in the same cycles that `in_ready` is 0.

## Test plan
- **Basic add:** reset, then send a=0x0000_000F, b=0x0000_0001, cin=0, sub=0 → `out_valid` at E8 with `sum`=0x0000_0010 and `cout`=0; `in_ready` returns to 1 after the handshake.
- **Full carry ripple:** a=0xFFFF_FFFF, b=0, cin=1 → `sum`=0x0000_0000, `cout`=1. Also check a=0x8000_0000, b=0x8000_0000, cin=0 → `sum`=0, `cout`=1.
- **Subtract:** a=5, b=7, sub=1, cin=1 → `sum`=0xFFFF_FFFE, `cout`=0 (cin is ignored). a=7, b=5, sub=1 → `sum`=2, `cout`=1.
- **Back-pressure:**
  - Hold `out_ready`=0 for 5 cycles after `out_valid` while driving `in_valid`=1 with new operands.
  - Required: `sum` and `cout` stay stable, `in_ready` stays 0 and the new operands are not accepted.
  - They are accepted at the first edge after the handshake where `in_ready`=1.
- **Reset mid-operation:**
  - Assert `rst` for one edge during the RUN cycle with `cnt`=4.
  - Required: `out_valid` never rises, `sum`=0, `cout`=0, and `in_ready`=1 in the cycle after `rst` deasserts.
  - A following add of 3+4 returns 7.
- **Random regression:** 1000 random {a, b, cin, sub} with random `out_ready` stalls are compared against the golden model {cout, sum} = a + (sub ? ~b : b) + (sub ? 1 : cin). Zero mismatches are allowed, and every result must appear exactly 8 cycles after its accept edge.
